// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler: arbitrates handshake and data-packet requests, drives the
// transmitter PID, tracks the transfer to completion and maintains the DATA0/DATA1 toggle.
module usb_tx_scheduler #(
    parameter int START_TIMEOUT = 16,
    parameter int LEN_W         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_req,
    input  logic [1:0]       hs_sel,
    output logic             hs_ack,
    input  logic             data_req,
    input  logic [LEN_W-1:0] data_len,
    output logic             data_ack,
    input  logic             toggle_clear,
    input  logic [LEN_W-1:0] buffer_occupancy,
    output logic [3:0]       tx_packet,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    output logic             busy,
    output logic             data_toggle,
    output logic             tx_done,
    output logic             tx_fail,
    output logic             fail_timeout
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        ACTIVE     = 3'd3,
        FINISH     = 3'd4
    } state_t;

    state_t           state_r;
    logic [3:0]       pid_r;
    logic             is_data_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    logic             data_ok_s;
    logic [3:0]       hs_pid_s;

    // Request eligibility and handshake PID decode (reserved selector maps to STALL)
    always_comb begin
        data_ok_s = data_req && (buffer_occupancy >= data_len);
        case (hs_sel)
            2'd0:    hs_pid_s = PID_ACK;
            2'd1:    hs_pid_s = PID_NAK;
            default: hs_pid_s = PID_STALL;
        endcase
    end

    // Scheduler FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            pid_r        <= 4'b0000;
            is_data_r    <= 1'b0;
            err_r        <= 1'b0;
            cnt_r        <= '0;
            tx_packet    <= 4'b0000;
            data_toggle  <= 1'b0;
            hs_ack       <= 1'b0;
            data_ack     <= 1'b0;
            tx_done      <= 1'b0;
            tx_fail      <= 1'b0;
            fail_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            hs_ack       <= 1'b0;
            data_ack     <= 1'b0;
            tx_done      <= 1'b0;
            tx_fail      <= 1'b0;
            fail_timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Foreign transmitter activity blocks any new issue
                    if (!tx_transfer_active && hs_req) begin
                        hs_ack    <= 1'b1;
                        pid_r     <= hs_pid_s;
                        is_data_r <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ISSUE;
                    end else if (!tx_transfer_active && data_ok_s) begin
                        data_ack  <= 1'b1;
                        pid_r     <= data_toggle ? PID_DATA1 : PID_DATA0;
                        is_data_r <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ISSUE;
                    end else begin
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                ISSUE: begin
                    tx_packet <= pid_r;
                    cnt_r     <= '0;
                    err_r     <= 1'b0;
                    state_r   <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_transfer_active) begin
                        tx_packet <= 4'b0000;
                        state_r   <= ACTIVE;
                    end else if (cnt_r == CNT_W'(START_TIMEOUT - 1)) begin
                        tx_packet    <= 4'b0000;
                        tx_fail      <= 1'b1;
                        fail_timeout <= 1'b1;
                        busy         <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    tx_packet <= 4'b0000;
                    err_r     <= err_r | tx_error;
                    if (!tx_transfer_active) begin
                        state_r <= FINISH;
                    end
                end
                FINISH: begin
                    if (err_r) begin
                        tx_fail <= 1'b1;
                    end else begin
                        tx_done <= 1'b1;
                        if (is_data_r) begin
                            data_toggle <= ~data_toggle;
                        end
                    end
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    tx_packet <= 4'b0000;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
            // A clear overrides a flip issued in the same cycle
            if (toggle_clear) begin
                data_toggle <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: expected PIDs and outcomes are queued as requests
// are driven, and popped when the DUT issues a PID or reports done/fail.
module tb_usb_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_req;
    logic [1:0] hs_sel;
    logic       hs_ack;
    logic       data_req;
    logic [6:0] data_len;
    logic       data_ack;
    logic       toggle_clear;
    logic [6:0] buffer_occupancy;
    logic [3:0] tx_packet;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       busy;
    logic       data_toggle;
    logic       tx_done;
    logic       tx_fail;
    logic       fail_timeout;

    usb_tx_scheduler #(.START_TIMEOUT(16), .LEN_W(7)) dut (
        .clk(clk), .rst(rst),
        .hs_req(hs_req), .hs_sel(hs_sel), .hs_ack(hs_ack),
        .data_req(data_req), .data_len(data_len), .data_ack(data_ack),
        .toggle_clear(toggle_clear), .buffer_occupancy(buffer_occupancy),
        .tx_packet(tx_packet), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .busy(busy), .data_toggle(data_toggle), .tx_done(tx_done), .tx_fail(tx_fail),
        .fail_timeout(fail_timeout)
    );

    always #5 clk = ~clk;

    // outcome kind: 0 = done, 1 = fail by tx_error, 2 = fail by start timeout
    typedef struct packed {
        logic [1:0] kind;
        logic       tog;
    } res_t;

    logic [3:0] pid_q[$];
    res_t       res_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    int xm_delay = 3;
    int xm_len   = 8;
    bit xm_en    = 1'b1;
    bit xm_err   = 1'b0;
    bit xm_clr   = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outcome_bits(input logic [1:0] kind);
        case (kind)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    // Scoreboard monitor: pops on new PID and on done/fail pulses
    initial begin
        logic [3:0] prev_pkt;
        res_t       r;
        prev_pkt = 4'b0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_pkt == 4'b0000 && tx_packet != 4'b0000) begin
                    if (pid_q.size() > 0) chk_eq("pid", tx_packet, pid_q.pop_front());
                    else                  chk_eq("unexpected_pid", tx_packet, 4'b0000);
                end
                if (tx_done || tx_fail) begin
                    if (res_q.size() > 0) begin
                        r = res_q.pop_front();
                        chk_eq("outcome", {tx_done, tx_fail, fail_timeout}, outcome_bits(r.kind));
                        chk_eq("toggle_after", data_toggle, r.tog);
                    end else begin
                        chk_eq("unexpected_outcome", {tx_done, tx_fail}, 2'b00);
                    end
                end
            end
            prev_pkt = tx_packet;
        end
    end

    // Transmitter model: raises active xm_delay cycles after a PID appears
    initial begin
        tx_transfer_active = 1'b0;
        tx_error           = 1'b0;
        toggle_clear       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && xm_en && tx_packet != 4'b0000) begin
                repeat (xm_delay) @(negedge clk);
                tx_transfer_active = 1'b1;
                for (int i = 0; i < xm_len; i++) begin
                    if (rst) break;
                    tx_error = xm_err && (i == xm_len / 2);
                    @(negedge clk);
                end
                tx_error           = 1'b0;
                tx_transfer_active = 1'b0;
                if (xm_clr && !rst) begin
                    @(negedge clk);
                    toggle_clear = 1'b1;
                    @(negedge clk);
                    toggle_clear = 1'b0;
                end
            end
        end
    end

    task automatic wait_ack(input bit is_hs);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (is_hs ? hs_ack : data_ack) break;
            n++;
        end
        chk_eq(is_hs ? "hs_ack_seen" : "data_ack_seen", n < 200, 1);
        if (is_hs) hs_req = 1'b0;
        else       data_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && (busy || res_q.size() != 0 || tx_transfer_active)) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_reached", n < 3000, 1);
        @(negedge clk);
    endtask

    task automatic send_hs(input logic [1:0] sel, input logic [3:0] pid, input res_t r);
        pid_q.push_back(pid);
        res_q.push_back(r);
        hs_sel = sel;
        hs_req = 1'b1;
        wait_ack(1'b1);
    endtask

    task automatic send_data(input logic [6:0] len, input logic [3:0] pid, input res_t r);
        pid_q.push_back(pid);
        res_q.push_back(r);
        data_len         = len;
        buffer_occupancy = len;
        data_req         = 1'b1;
        wait_ack(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        hs_req = 1'b0; hs_sel = 2'd0; data_req = 1'b0; data_len = 7'd0; buffer_occupancy = 7'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset state
        chk_eq("rst_tx_packet", tx_packet, 4'b0000);
        chk_eq("rst_toggle", data_toggle, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_pulses", {hs_ack, data_ack, tx_done, tx_fail, fail_timeout}, 5'b00000);

        // 2. ACK with long transfer; PID drops once active is seen
        xm_len = 1000;
        send_hs(2'd0, 4'b0010, '{kind: 2'd0, tog: 1'b0});
        chk_eq("busy_after_ack", busy, 1'b1);
        n = 0;
        while (n < 100 && !tx_transfer_active) begin @(negedge clk); n++; end
        @(negedge clk);
        chk_eq("pid_cleared_on_active", tx_packet, 4'b0000);
        wait_idle();
        xm_len = 8;

        // 3. DATA0 then DATA1, boundary lengths 1 and 64
        send_data(7'd1,  4'b0011, '{kind: 2'd0, tog: 1'b1});
        wait_idle();
        send_data(7'd64, 4'b1011, '{kind: 2'd0, tog: 1'b0});
        wait_idle();

        // 4. NAK wins over a simultaneous eligible data request
        pid_q.push_back(4'b1010); res_q.push_back('{kind: 2'd0, tog: 1'b0});
        pid_q.push_back(4'b0011); res_q.push_back('{kind: 2'd0, tog: 1'b1});
        hs_sel = 2'd1; hs_req = 1'b1;
        data_len = 7'd4; buffer_occupancy = 7'd4; data_req = 1'b1;
        wait_ack(1'b1);
        chk_eq("data_ack_held", data_ack, 1'b0);
        wait_ack(1'b0);
        wait_idle();

        // 5. ineligible data request waits for occupancy
        pid_q.push_back(4'b1011); res_q.push_back('{kind: 2'd0, tog: 1'b0});
        data_len = 7'd10; buffer_occupancy = 7'd5; data_req = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk); if (data_ack) n++; end
        chk_eq("no_ack_short_buffer", n, 0);
        buffer_occupancy = 7'd10;
        @(negedge clk);
        chk_eq("ack_when_filled", data_ack, 1'b1);
        data_req = 1'b0;
        wait_idle();

        // 5b. tx_error during ACTIVE: fail, toggle unchanged
        xm_err = 1'b1;
        send_data(7'd3, 4'b0011, '{kind: 2'd1, tog: 1'b0});
        wait_idle();
        xm_err = 1'b0;

        // 6. start timeout: fail 17 cycles after the ack
        xm_en = 1'b0;
        send_hs(2'd2, 4'b1110, '{kind: 2'd2, tog: 1'b0});
        n = 0;
        while (n < 100 && !tx_fail) begin @(negedge clk); n++; end
        chk_eq("timeout_latency", n, 17);
        chk_eq("timeout_pid_cleared", tx_packet, 4'b0000);
        wait_idle();
        xm_en = 1'b1;

        // reserved selector behaves as STALL
        send_hs(2'd3, 4'b1110, '{kind: 2'd0, tog: 1'b0});
        wait_idle();

        // 6b. toggle_clear in the FINISH cycle beats the flip
        xm_clr = 1'b1;
        send_data(7'd0, 4'b0011, '{kind: 2'd0, tog: 1'b0});
        wait_idle();
        xm_clr = 1'b0;
        send_data(7'd2, 4'b0011, '{kind: 2'd0, tog: 1'b1});
        wait_idle();

        // 1b. reset mid-ACTIVE abandons the packet silently
        xm_len = 40;
        pid_q.push_back(4'b1011);
        data_len = 7'd8; buffer_occupancy = 7'd8; data_req = 1'b1;
        wait_ack(1'b0);
        n = 0;
        while (n < 100 && !tx_transfer_active) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_eq("midrst_tx_packet", tx_packet, 4'b0000);
        chk_eq("midrst_toggle", data_toggle, 1'b0);
        chk_eq("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        xm_len = 8;
        wait_idle();
        repeat (5) @(negedge clk);
        chk_eq("pid_q_drained", pid_q.size(), 0);
        chk_eq("res_q_drained", res_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Sequences the USB transmitter: accepts handshake requests (ACK/NAK/STALL) from the receive-side protocol logic and data-packet requests from the endpoint/AHB side.
- Arbitrates between the two, drives the transmitter's tx_packet PID, and tracks the transmitter through tx_transfer_active to completion.
- Maintains the DATA0/DATA1 toggle and reports success, failure and start-timeout to the requesters.

Parameters:
START_TIMEOUT, 16, max clk cycles to wait for tx_transfer_active to rise after issuing a PID
LEN_W, 7, width of length/occupancy fields (max 64-byte payload)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
hs_req  in  1  handshake request, level, held until hs_ack
hs_sel  in  2  0=ACK, 1=NAK, 2=STALL, 3=reserved (treated as STALL)
hs_ack  out  1  one-cycle pulse: handshake request captured
data_req  in  1  data packet request, level, held until data_ack
data_len  in  LEN_W  payload byte count (0..64)
data_ack  out  1  one-cycle pulse: data request captured
toggle_clear  in  1  pulse: force next data PID to DATA0
buffer_occupancy  in  LEN_W  bytes currently in TX FIFO
tx_packet  out  4  PID to transmitter; 0000 when idle
tx_transfer_active  in  1  transmitter busy
tx_error  in  1  transmitter error flag
busy  out  1  high whenever state != IDLE
data_toggle  out  1  PID to be used for the next data packet (0=DATA0, 1=DATA1)
tx_done  out  1  one-cycle pulse: packet completed without error
tx_fail  out  1  one-cycle pulse: packet failed (tx_error or start timeout)
fail_timeout  out  1  registered alongside tx_fail: 1=start timeout, 0=tx_error

Behaviour:
- Reset (async, rst=1): state IDLE; tx_packet=0000; data_toggle=0; hs_ack, data_ack, tx_done, tx_fail, fail_timeout, busy=0; timeout counter=0. Reset mid-packet abandons it; no done/fail pulse.
- PID codes: ACK=0010, NAK=1010, STALL=1110, DATA0=0011, DATA1=1011.
- States: IDLE, ISSUE, WAIT_START, ACTIVE, FINISH.
- IDLE:
  - Eligible data request: data_req=1 and buffer_occupancy >= data_len. Zero-length packets are always eligible.
  - If hs_req=1, the handshake wins, even when an eligible data request is present in the same cycle. Pulse hs_ack, latch the PID, go to ISSUE.
  - Otherwise, if a data request is eligible: pulse data_ack, latch {data_toggle ? DATA1 : DATA0}, mark the packet as data, go to ISSUE.
  - A data request that is not eligible stays pending with no ack; handshakes are still served meanwhile.
  - IDLE with tx_transfer_active=1 (foreign activity): no new PID is issued until it clears.
- ISSUE: drive the latched PID on tx_packet; clear the timeout counter; next cycle go to WAIT_START.
- WAIT_START:
  - Hold tx_packet; increment the counter each cycle.
  - If tx_transfer_active=1, go to ACTIVE and tx_packet=0000 on the next edge.
  - If the counter reaches START_TIMEOUT first: tx_packet=0000, tx_fail=1, fail_timeout=1, go to IDLE. The toggle is unchanged.
- ACTIVE:
  - tx_packet=0000; wait for tx_transfer_active=0, then go to FINISH.
  - tx_error seen high at any cycle in ACTIVE is sticky-captured for this packet.
- FINISH (one cycle):
  - Error captured: tx_fail=1, fail_timeout=0.
  - Otherwise: tx_done=1, and for a data packet data_toggle flips.
  - Go to IDLE. A new request may be accepted the cycle after FINISH (one idle cycle minimum between packets).
- toggle_clear: sets data_toggle=0 on the next edge in any state. It takes priority over a flip in the same cycle. It does not alter an already-latched PID.
- Handshake packets never modify data_toggle.
- All outputs are registered. The ack pulse and the ISSUE entry occur in the same edge; tx_packet is valid one cycle after the ack.

Test Plan:
1. After reset: tx_packet=0000, data_toggle=0, busy=0, all pulses 0. Assert rst mid-ACTIVE -> immediate return to these values.
2. hs_req=1, hs_sel=0 -> hs_ack pulse, tx_packet=0010. TB model raises active after 3 cycles, drops after 1000 -> tx_packet=0000 once active is seen, tx_done pulse, data_toggle stays 0.
3. data_req with data_len=1, buffer_occupancy=1 -> tx_packet=0011, success, data_toggle=1. Repeat with data_len=64, occupancy=64 -> tx_packet=1011, data_toggle=0.
4. hs_req (NAK) and eligible data_req in the same cycle -> NAK (1010) issued first, data_ack held. After tx_done, the data packet is issued with tx_packet=0011.
5. data_len=10, occupancy=5 -> no data_ack; raise occupancy to 10 -> data_ack next cycle. Separately, assert tx_error during ACTIVE -> tx_fail=1, fail_timeout=0, toggle unchanged.
6. Transmitter never raises active -> after 16 cycles, tx_fail=1, fail_timeout=1, tx_packet=0000. Separately, toggle_clear in the same FINISH cycle as a successful data packet -> data_toggle=0.
